// File: rtl/lifo_stack_pkg.sv
// Shared sizing helpers for the LIFO stack: count width and almost-full threshold.
package lifo_stack_pkg;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int unsigned usedw_width(input int unsigned awidth);
    return awidth + 32'd1;
  endfunction

  // Almost-full threshold, clamped at zero when the margin exceeds the depth.
  function automatic int unsigned af_threshold(input int unsigned depth,
                                               input int unsigned almost_full);
    return (almost_full >= depth) ? 32'd0 : depth - almost_full;
  endfunction

endpackage : lifo_stack_pkg

// File: rtl/lifo_stack_ram.sv
// Simple dual-port RAM: synchronous write, registered read (read-before-write).
module lifo_stack_ram #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] q_o
);

  localparam int unsigned DEPTH = 32'd1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Write port; contents are intentionally never cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  q_o <= '0;
    else if (re_i)  q_o <= mem[raddr_i];
  end

endmodule : lifo_stack_ram

// File: rtl/lifo_stack.sv
// LIFO stack with registered pop data, occupancy count and status flags.
// Optional sticky overflow/underflow outputs when LIFO_STACK_ERR_EN is defined.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int unsigned DWIDTH       = 16,
  parameter int unsigned AWIDTH       = 8,
  parameter int unsigned ALMOST_FULL  = 2,
  parameter int unsigned ALMOST_EMPTY = 2
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                wrreq_i,
  input  logic [DWIDTH-1:0]   data_i,
  input  logic                rdreq_i,
  output logic [DWIDTH-1:0]   q_o,
  output logic                almost_empty_o,
  output logic                empty_o,
  output logic                almost_full_o,
  output logic                full_o,
  output logic [AWIDTH:0]     usedw_o
`ifdef LIFO_STACK_ERR_EN
  ,
  output logic                overflow_o,
  output logic                underflow_o
`endif
);

  localparam int unsigned DEPTH     = 32'd1 << AWIDTH;
  localparam int unsigned UW        = usedw_width(AWIDTH);
  localparam int unsigned AF_THRESH = af_threshold(DEPTH, ALMOST_FULL);

  logic [UW-1:0]     usedw_q;
  logic              empty;
  logic              full;
  logic              pop_ok;
  logic              push_ok;
  logic              ram_we;
  logic [AWIDTH-1:0] top_addr;
  logic [AWIDTH-1:0] ram_waddr;

  // Request qualification; a pop with a push overwrites the top in place.
  always_comb begin
    empty     = (usedw_q == '0);
    full      = (32'(usedw_q) == DEPTH);
    pop_ok    = rdreq_i && !empty;
    push_ok   = wrreq_i && !full && !pop_ok;
    top_addr  = AWIDTH'(usedw_q - UW'(1));
    ram_we    = push_ok || (wrreq_i && pop_ok);
    ram_waddr = pop_ok ? top_addr : AWIDTH'(usedw_q);
  end

  // Occupancy count; guards above keep it within 0..DEPTH.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                usedw_q <= '0;
    else if (pop_ok && !wrreq_i)  usedw_q <= usedw_q - UW'(1);
    else if (push_ok)             usedw_q <= usedw_q + UW'(1);
  end

  lifo_stack_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .we_i     (ram_we),
    .waddr_i  (ram_waddr),
    .wdata_i  (data_i),
    .re_i     (pop_ok),
    .raddr_i  (top_addr),
    .q_o      (q_o)
  );

  // Status flags follow the count register directly.
  assign usedw_o        = usedw_q;
  assign empty_o        = empty;
  assign full_o         = full;
  assign almost_empty_o = (32'(usedw_q) <= ALMOST_EMPTY);
  assign almost_full_o  = (32'(usedw_q) >= AF_THRESH);

`ifdef LIFO_STACK_ERR_EN
  // Sticky error flags for dropped pushes and ignored pops.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wrreq_i && full && !rdreq_i) overflow_o  <= 1'b1;
      if (rdreq_i && empty)            underflow_o <= 1'b1;
    end
  end
`endif

endmodule : lifo_stack

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed scenarios plus random push/pop
// traffic compared against a queue-based reference model.
module tb_lifo_stack;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int          DEPTH = 256;
  localparam int          AF    = 2;
  localparam int          AE    = 2;

  logic          clk    = 1'b0;
  logic          arst_n = 1'b0;
  logic          wrreq  = 1'b0;
  logic          rdreq  = 1'b0;
  logic [DW-1:0] data   = '0;
  logic [DW-1:0] q;
  logic          almost_empty, empty, almost_full, full;
  logic [AW:0]   usedw;
`ifdef LIFO_STACK_ERR_EN
  logic          ovf, unf;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [DW-1:0] stk[$];
  logic [DW-1:0] m_q   = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  lifo_stack #(
    .DWIDTH       (DW),
    .AWIDTH       (AW),
    .ALMOST_FULL  (AF),
    .ALMOST_EMPTY (AE)
  ) dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .wrreq_i        (wrreq),
    .data_i         (data),
    .rdreq_i        (rdreq),
    .q_o            (q),
    .almost_empty_o (almost_empty),
    .empty_o        (empty),
    .almost_full_o  (almost_full),
    .full_o         (full),
    .usedw_o        (usedw)
`ifdef LIFO_STACK_ERR_EN
    ,
    .overflow_o     (ovf),
    .underflow_o    (unf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the model.
  task automatic check_all(input string tag);
    int n;
    n = stk.size();
    check({tag, "_q"},     32'(q),            32'(m_q));
    check({tag, "_usedw"}, 32'(usedw),        32'(n));
    check({tag, "_empty"}, 32'(empty),        32'(n == 0));
    check({tag, "_full"},  32'(full),         32'(n == DEPTH));
    check({tag, "_aempt"}, 32'(almost_empty), 32'(n <= AE));
    check({tag, "_afull"}, 32'(almost_full),  32'(n >= DEPTH - AF));
`ifdef LIFO_STACK_ERR_EN
    check({tag, "_ovf"},   32'(ovf),          32'(m_ovf));
    check({tag, "_unf"},   32'(unf),          32'(m_unf));
`endif
  endtask

  // Stack semantics applied at a clock edge.
  task automatic model_edge(input bit wr, input bit rd, input logic [DW-1:0] d);
    int n;
    n = stk.size();
    if (rd && n > 0) begin
      m_q = stk[n-1];
      if (wr) stk[n-1] = d;
      else    void'(stk.pop_back());
    end else begin
      if (rd) m_unf = 1'b1;
      if (wr) begin
        if (n < DEPTH) stk.push_back(d);
        else           m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input string tag, input bit wr, input bit rd, input logic [DW-1:0] d);
    @(negedge clk);
    wrreq = wr;
    rdreq = rd;
    data  = d;
    @(posedge clk);
    model_edge(wr, rd, d);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges and check outputs react without a clock.
  task automatic mid_reset(input string tag);
    #2;
    arst_n = 1'b0;
    wrreq  = 1'b0;
    rdreq  = 1'b0;
    #1;
    stk.delete();
    m_q   = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_all(tag);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] last;
    int pw, pr;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    arst_n = 1'b1;
    step("idle", 1'b0, 1'b0, '0);
    check("idle_afull_const", 32'(almost_full), 32'd0);

    // Push 1,2,3 then pop three times
    step("push1", 1'b1, 1'b0, 16'h0001);
    step("push2", 1'b1, 1'b0, 16'h0002);
    step("push3", 1'b1, 1'b0, 16'h0003);
    step("pop1", 1'b0, 1'b1, '0);
    check("pop1_const", 32'(q), 32'h3);
    step("pop2", 1'b0, 1'b1, '0);
    check("pop2_const", 32'(q), 32'h2);
    step("pop3", 1'b0, 1'b1, '0);
    check("pop3_const", 32'(q), 32'h1);
    check("pop3_empty", 32'(empty), 32'd1);

    // Pop on empty: q holds
    step("pop_empty", 1'b0, 1'b1, '0);
    check("pop_empty_hold", 32'(q), 32'h1);

    // Fill to full, then an extra push is dropped
    for (int i = 1; i <= DEPTH; i++) begin
      last = DW'($urandom);
      step("fill", 1'b1, 1'b0, last);
      if (i == DEPTH - AF - 1) check("af_below", 32'(almost_full), 32'd0);
      if (i == DEPTH - AF)     check("af_rise",  32'(almost_full), 32'd1);
    end
    check("full_set", 32'(full), 32'd1);
    step("push_full", 1'b1, 1'b0, ~last);
    check("push_full_usedw", 32'(usedw), 32'(DEPTH));
    step("pop_after_full", 1'b0, 1'b1, '0);
    check("pop_after_full_q", 32'(q), 32'(last));

    // Simultaneous push/pop with 5 entries
    mid_reset("rst_a");
    for (int i = 0; i < 4; i++) step("pre5", 1'b1, 1'b0, DW'($urandom));
    step("push_aa", 1'b1, 1'b0, 16'h00AA);
    step("swap", 1'b1, 1'b1, 16'h00BB);
    check("swap_q", 32'(q), 32'h00AA);
    check("swap_usedw", 32'(usedw), 32'd5);
    step("pop_bb", 1'b0, 1'b1, '0);
    check("pop_bb_q", 32'(q), 32'h00BB);

    // Simultaneous requests on empty stack: push only
    mid_reset("rst_b");
    step("swap_empty", 1'b1, 1'b1, 16'h5A5A);
    check("swap_empty_usedw", 32'(usedw), 32'd1);

    // Reset mid-stream with 10 entries
    for (int i = 0; i < 9; i++) step("pre10", 1'b1, 1'b0, DW'($urandom));
    check("ten_usedw", 32'(usedw), 32'd10);
    mid_reset("rst_mid");
    check("rst_mid_usedw", 32'(usedw), 32'd0);
    step("push_1234", 1'b1, 1'b0, 16'h1234);
    step("pop_1234", 1'b0, 1'b1, '0);
    check("pop_1234_q", 32'(q), 32'h1234);
    check("pop_1234_usedw", 32'(usedw), 32'd0);

    // Random traffic with phase-dependent bias to sweep empty..full
    for (int p = 0; p < 6; p++) begin
      case (p)
        0: begin pw = 80; pr = 20; end
        1: begin pw = 90; pr = 10; end
        2: begin pw = 50; pr = 50; end
        3: begin pw = 10; pr = 90; end
        4: begin pw = 60; pr = 60; end
        default: begin pw = 30; pr = 70; end
      endcase
      for (int c = 0; c < 400; c++) begin
        step("rand", ($urandom_range(99) < pw), ($urandom_range(99) < pr), DW'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lifo_stack
